imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 213 +++++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : Immediate-decode pipeline stage with skid buffering. Decodes
//               the immediate of a 32-bit RV instruction word, extends it to
//               XLEN (32 or 64) and tags it with a format code. The result is
//               registered with the instruction and PC, so out_* follow an
//               accept by exactly one cycle. A main register plus one skid
//               register keep full throughput under back-pressure, and
//               in_ready depends only on registered state.
// Ports       : clk, rst_n (async, active-low), flush (sync discard)
//               in_valid/in_ready/in_instr/in_pc   upstream handshake
//               out_valid/out_ready/out_imm/out_fmt/out_instr/out_pc
//               out_illegal (only with IMM_ILLEGAL_CHK_EN defined)
// Config      : `define IMM_ILLEGAL_CHK_EN adds out_illegal, which is set
//               when instr[1:0] != 2'b11 or the format is NONE.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc
`ifdef IMM_ILLEGAL_CHK_EN
  ,
  output logic            out_illegal
`endif
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_decode_stage: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_SH   = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
`ifdef IMM_ILLEGAL_CHK_EN
    logic            illegal;
`endif
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t w_new;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [5:0] w_shamt;
  logic       w_accept;
  logic       w_pop;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  // RV64 shifts use a 6-bit shamt; on RV32 bit 25 belongs to funct7.
  assign w_shamt  = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  // Decode the incoming word into the entry that will be registered.
  always_comb begin
    w_new       = '0;
    w_new.instr = in_instr;
    w_new.pc    = in_pc;
    w_new.fmt   = FMT_NONE;
    w_new.imm   = '0;
    case (w_opcode)
      OP_IMM: begin
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          w_new.fmt = FMT_SH;
          w_new.imm = XLEN'(w_shamt);
        end else begin
          w_new.fmt = FMT_I;
          w_new.imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      OP_LOAD, OP_JALR: begin
        w_new.fmt = FMT_I;
        w_new.imm = XLEN'($signed(in_instr[31:20]));
      end
      OP_STORE: begin
        w_new.fmt = FMT_S;
        w_new.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_BRANCH: begin
        w_new.fmt = FMT_B;
        w_new.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        w_new.fmt = FMT_U;
        w_new.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        w_new.fmt = FMT_J;
        w_new.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0}));
      end
      OP_SYSTEM: begin
        // Only the immediate CSR forms carry a zimm; ECALL/CSRRx stay NONE.
        if (in_instr[14]) begin
          w_new.fmt = FMT_Z;
          w_new.imm = XLEN'(in_instr[19:15]);
        end
      end
      default: ;
    endcase
`ifdef IMM_ILLEGAL_CHK_EN
    w_new.illegal = (in_instr[1:0] != 2'b11) || (w_new.fmt == FMT_NONE);
`endif
  end

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_accept) begin
            main_d  = w_new;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            main_d = w_new;
          end else if (w_accept) begin
            skid_d  = w_new;
            state_d = ST_TWO;
          end else if (w_pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_imm   = main_q.imm;
  assign out_fmt   = main_q.fmt;
  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;
`ifdef IMM_ILLEGAL_CHK_EN
  assign out_illegal = main_q.illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_stage
// Description : Bench for imm_decode_stage. Drives an XLEN=32 and an XLEN=64
//               instance from the same stimulus and compares both against a
//               queue-based reference of the stage contents and an arithmetic
//               immediate model. Honours IMM_ILLEGAL_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy32, ov32, rdy64, ov64;
  logic [31:0] imm32, oinstr32, opc32, oinstr64;
  logic [63:0] imm64, opc64;
  logic [2:0]  fmt32, fmt64;
`ifdef IMM_ILLEGAL_CHK_EN
  logic        ill32, ill64;
`endif

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_instr(oinstr32), .out_pc(opc32)
`ifdef IMM_ILLEGAL_CHK_EN
    , .out_illegal(ill32)
`endif
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_instr(oinstr64), .out_pc(opc64)
`ifdef IMM_ILLEGAL_CHK_EN
    , .out_illegal(ill64)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Format code straight from the opcode table.
  function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
    case (ins[6:0])
      7'b0010011:             return (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? 3'd7 : 3'd1;
      7'b0000011, 7'b1100111: return 3'd1;
      7'b0100011:             return 3'd2;
      7'b1100011:             return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      7'b1101111:             return 3'd5;
      7'b1110011:             return ins[14] ? 3'd6 : 3'd0;
      default:                return 3'd0;
    endcase
  endfunction

  // Immediate as a signed integer built from weighted fields; the sign bit
  // contributes its negative weight. Returned as 64-bit two's complement.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int xlen);
    longint v = 0;
    longint s = ins[31] ? 1 : 0;
    case (ref_fmt(ins))
      3'd1: v = longint'(ins[31:20]) - s * 4096;
      3'd2: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - s * 4096;
      3'd3: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
              + longint'(ins[11:8]) * 2 - s * 4096;
      3'd4: v = longint'(ins[31:12]) * 4096 - s * 64'sh1_0000_0000;
      3'd5: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
              + longint'(ins[30:21]) * 2 - s * 1048576;
      3'd6: v = longint'(ins[19:15]);
      3'd7: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  task automatic check_outputs();
    logic [63:0] r;
    logic        exp_rdy, exp_ov;
    exp_rdy = (q.size() < 2);
    exp_ov  = (q.size() > 0);
    chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
    chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
    chk("out_valid32", 64'(ov32), 64'(exp_ov));
    chk("out_valid64", 64'(ov64), 64'(exp_ov));
    if (q.size() > 0) begin
      r = ref_imm(q[0].instr, 32);
      chk("imm32", 64'(imm32), {32'b0, r[31:0]});
      chk("imm64", imm64, ref_imm(q[0].instr, 64));
      chk("fmt32", 64'(fmt32), 64'(ref_fmt(q[0].instr)));
      chk("fmt64", 64'(fmt64), 64'(ref_fmt(q[0].instr)));
      chk("instr32", 64'(oinstr32), 64'(q[0].instr));
      chk("instr64", 64'(oinstr64), 64'(q[0].instr));
      r = q[0].pc;
      chk("pc32", 64'(opc32), {32'b0, r[31:0]});
      chk("pc64", opc64, q[0].pc);
`ifdef IMM_ILLEGAL_CHK_EN
      r = 64'((q[0].instr[1:0] != 2'b11) || (ref_fmt(q[0].instr) == 3'd0));
      chk("illegal32", 64'(ill32), r);
      chk("illegal64", 64'(ill64), r);
`endif
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'({ov32, ov64}), 64'd0);
    chk({tag, "_ready"}, 64'({rdy32, rdy64}), 64'd3);
    chk({tag, "_imm"}, 64'(imm32) | imm64, 64'd0);
    chk({tag, "_fmt"}, 64'({fmt32, fmt64}), 64'd0);
    chk({tag, "_instr"}, {oinstr32, oinstr64}, 64'd0);
    chk({tag, "_pc"}, 64'(opc32) | opc64, 64'd0);
`ifdef IMM_ILLEGAL_CHK_EN
    chk({tag, "_illegal"}, 64'({ill32, ill64}), 64'd0);
`endif
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic ordy, input logic fl);
    logic acc, pop;
    ent_t e;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #3;
    check_outputs();
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.instr = ins;
        e.pc    = pc;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11] = '{7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  initial begin
    ent_t e;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #2;
    chk_reset("reset");

    // ADDI -1 offered while still in reset; accepted on the first edge after release.
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h0000_0000_8000_0000; out_ready = 1'b1;
    #10 rst_n = 1'b1;
    e.instr = in_instr; e.pc = in_pc; q.push_back(e);
    @(posedge clk); #1;
    chk("addi_valid", 64'(ov32), 64'd1);
    chk("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(fmt32), 64'd1);

    step(1'b1, 32'hFFDFF06F, 64'h1004, 1'b1, 1'b0);
    chk("jal_imm32", 64'(imm32), 64'hFFFF_FFFC);
    chk("jal_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal_fmt", 64'(fmt64), 64'd5);
    step(1'b1, 32'h4030D093, 64'h1008, 1'b1, 1'b0);
    chk("srai_imm", 64'(imm32) | imm64, 64'd3);
    chk("srai_fmt", 64'(fmt32), 64'd7);
    step(1'b1, 32'h123452B7, 64'h100C, 1'b1, 1'b0);
    chk("lui_imm64", imm64, 64'h0000_0000_1234_5000);
    chk("lui_fmt", 64'(fmt64), 64'd4);
    step(1'b1, 32'h00000073, 64'h1010, 1'b1, 1'b0);  // ECALL -> NONE
    step(1'b1, 32'h3400D073, 64'h1014, 1'b1, 1'b0);  // CSRRWI zimm=1
`ifdef IMM_ILLEGAL_CHK_EN
    step(1'b1, 32'h00000000, 64'h1018, 1'b1, 1'b0);
    chk("zero_illegal", 64'(ill32), 64'd1);
    chk("zero_imm", 64'(imm32), 64'd0);
    chk("zero_fmt", 64'(fmt32), 64'd0);
`endif
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Back-pressure: A, B accepted, C held upstream until space frees.
    step(1'b1, 32'h00100093, 64'hA0, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 64'hB0, 1'b0, 1'b0);
    chk("full_ready", 64'(rdy32), 64'd0);
    step(1'b1, 32'h00300193, 64'hC0, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 64'hC0, 1'b1, 1'b0);
    step(1'b1, 32'h00300193, 64'hC0, 1'b1, 1'b0);
    chk("order_c", 64'(oinstr32), 64'h0030_0193);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Flush while full with an input on offer.
    step(1'b1, 32'h00400213, 64'hD0, 1'b0, 1'b0);
    step(1'b1, 32'h00500293, 64'hE0, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 64'hF0, 1'b1, 1'b1);
    chk("flush_valid", 64'(ov32), 64'd0);
    chk("flush_ready", 64'(rdy64), 64'd1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Asynchronous reset while entries are held.
    step(1'b1, 32'h00700393, 64'h110, 1'b0, 1'b0);
    step(1'b1, 32'h00800413, 64'h120, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("midreset");
    q.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
